mux: RTL and testbench

- Return-path counterpart of the word-to-byte demux. Sits between the three decryption blocks and the master side.
- Accepts SYS_DWIDTH-bit characters from the one decryption output chosen by select and packs each group of MST_DWIDTH/SYS_DWIDTH characters into one MST_DWIDTH-bit word.
- Emits each completed word as a single-cycle valid pulse. All logic runs in the clk_sys domain.

---
 rtl/mux.sv | 138 +++++++++++++
 tb/tb_mux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux.sv
// Packs SYS_DWIDTH characters from one of three selected decryption channels into MST_DWIDTH words.
// Optional MUX_PARTIAL_FLUSH_EN: flush partial words on select change (adds last_cnt_o) instead of dropping.
`timescale 1ns/1ps

module mux #(
    parameter int unsigned MST_DWIDTH = 32,
    parameter int unsigned SYS_DWIDTH = 8
) (
    input  logic                                   clk_sys,
    input  logic                                   rst,
    input  logic [1:0]                             select,
    input  logic [SYS_DWIDTH-1:0]                  data0_i,
    input  logic                                   valid0_i,
    input  logic [SYS_DWIDTH-1:0]                  data1_i,
    input  logic                                   valid1_i,
    input  logic [SYS_DWIDTH-1:0]                  data2_i,
    input  logic                                   valid2_i,
`ifdef MUX_PARTIAL_FLUSH_EN
    output logic [$clog2(MST_DWIDTH/SYS_DWIDTH):0] last_cnt_o,
`endif
    output logic [MST_DWIDTH-1:0]                  data_o,
    output logic                                   valid_o,
    output logic                                   drop_o
);

    localparam int unsigned NB = MST_DWIDTH / SYS_DWIDTH;
    localparam int unsigned CW = $clog2(NB);
    localparam int unsigned LW = CW + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [MST_DWIDTH-1:0] pack_q, pack_d;
    logic [1:0]            sel_q;
    logic [MST_DWIDTH-1:0] data_d;
    logic                  valid_d;
    logic                  drop_d;
    logic [SYS_DWIDTH-1:0] sel_data;
    logic                  accept;
    logic                  change;
`ifdef MUX_PARTIAL_FLUSH_EN
    logic [LW-1:0]         last_d;
`endif

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pack_q     <= '0;
            sel_q      <= 2'd0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            drop_o     <= 1'b0;
`ifdef MUX_PARTIAL_FLUSH_EN
            last_cnt_o <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pack_q     <= pack_d;
            sel_q      <= select;
            data_o     <= data_d;
            valid_o    <= valid_d;
            drop_o     <= drop_d;
`ifdef MUX_PARTIAL_FLUSH_EN
            last_cnt_o <= last_d;
`endif
        end
    end

    // Channel selection, packing and next-state logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pack_d   = pack_q;
        data_d   = data_o;
        valid_d  = 1'b0;
        drop_d   = 1'b0;
        sel_data = '0;
        accept   = 1'b0;
`ifdef MUX_PARTIAL_FLUSH_EN
        last_d   = last_cnt_o;
`endif

        case (select)
            2'd0: begin sel_data = data0_i; accept = valid0_i; end
            2'd1: begin sel_data = data1_i; accept = valid1_i; end
            2'd2: begin sel_data = data2_i; accept = valid2_i; end
            default: begin sel_data = '0; accept = 1'b0; end
        endcase

        change = (select != sel_q) && (state_q == COLLECT);

        if (change) begin
`ifdef MUX_PARTIAL_FLUSH_EN
            // Unfilled low characters are already zero because each word starts from a cleared register
            data_d  = pack_q;
            valid_d = 1'b1;
            last_d  = LW'(count_q);
`else
            drop_d  = 1'b1;
`endif
            state_d = IDLE;
            count_d = '0;
        end

        if (accept) begin
            if (change || (state_q == IDLE)) begin
                pack_d  = {sel_data, {(MST_DWIDTH-SYS_DWIDTH){1'b0}}};
                count_d = CW'(1);
                state_d = COLLECT;
            end else begin
                for (int unsigned k = 0; k < NB; k++) begin
                    if (count_q == CW'(k)) begin
                        pack_d[MST_DWIDTH-1-k*SYS_DWIDTH -: SYS_DWIDTH] = sel_data;
                    end
                end
                if (count_q == CW'(NB-1)) begin
                    data_d  = pack_d;
                    valid_d = 1'b1;
`ifdef MUX_PARTIAL_FLUSH_EN
                    last_d  = LW'(NB);
`endif
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mux.sv
// Table-driven scoreboard bench for mux: per-cycle stimulus with expected registered outputs.
`timescale 1ns/1ps

module tb_mux;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [1:0]  select;
    logic [7:0]  data0_i, data1_i, data2_i;
    logic        valid0_i, valid1_i, valid2_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        drop_o;
`ifdef MUX_PARTIAL_FLUSH_EN
    logic [2:0]  last_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    mux #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .select    (select),
        .data0_i   (data0_i),
        .valid0_i  (valid0_i),
        .data1_i   (data1_i),
        .valid1_i  (valid1_i),
        .data2_i   (data2_i),
        .valid2_i  (valid2_i),
`ifdef MUX_PARTIAL_FLUSH_EN
        .last_cnt_o(last_cnt_o),
`endif
        .data_o    (data_o),
        .valid_o   (valid_o),
        .drop_o    (drop_o)
    );

    typedef struct {
        string       tag;
        logic        rst;
        logic [1:0]  sel;
        logic        v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic        v2;
        logic [7:0]  d2;
        logic        ev;     // expected valid_o after this cycle's edge
        logic        ed;     // expected drop_o
        logic        cd;     // compare data_o even when not valid
        logic [31:0] edata;
        int          ecnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(string tag, logic r, logic [1:0] sel,
                                logic v0, logic [7:0] d0, logic v1, logic [7:0] d1,
                                logic v2, logic [7:0] d2, logic ev, logic ed, logic cd,
                                logic [31:0] edata, int ecnt);
        vec_t v;
        v.tag = tag; v.rst = r; v.sel = sel;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2;
        v.ev = ev; v.ed = ed; v.cd = cd; v.edata = edata; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic check_bit(string name, logic got, logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0b want=%0b", name, got, want);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge
    task automatic step(vec_t v);
        vec_t e;
        rst      = v.rst;
        select   = v.sel;
        valid0_i = v.v0; data0_i = v.d0;
        valid1_i = v.v1; data1_i = v.d1;
        valid2_i = v.v2; data2_i = v.d2;
        exp_q.push_back(v);
        @(posedge clk_sys);
        #1;
        e = exp_q.pop_front();
        check_bit({e.tag, " valid_o"}, valid_o, e.ev);
        check_bit({e.tag, " drop_o"}, drop_o, e.ed);
        if (e.ev || e.cd) begin
            checks++;
            if (data_o !== e.edata) begin
                failures++;
                $display("FAIL %s data_o got=%h want=%h", {e.tag, ""}, data_o, e.edata);
            end
        end
`ifdef MUX_PARTIAL_FLUSH_EN
        if (e.ev) begin
            checks++;
            if (int'(last_cnt_o) != e.ecnt) begin
                failures++;
                $display("FAIL %s last_cnt_o got=%0d want=%0d", {e.tag, ""}, last_cnt_o, e.ecnt);
            end
        end
`endif
    endtask

    initial begin
        logic [7:0] d;
        logic       ev;
        logic       odd;

        rst = 1'b1; select = 2'd0;
        valid0_i = 1'b0; valid1_i = 1'b0; valid2_i = 1'b0;
        data0_i = '0; data1_i = '0; data2_i = '0;

        // Reset state
        tbl.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
        tbl.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0));

        // Single word on channel 0, then the pulse must drop while data holds
        for (int i = 0; i < 4; i++) begin
            d  = 8'(8'h41 + i);
            ev = (i == 3);
            tbl.push_back(mk("t1_word", 0, 0, 1, d, 0, 0, 0, 0, ev, 0, ev, 32'h41424344, 4));
        end
        tbl.push_back(mk("t1_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h41424344, 0));

        // Back-to-back words on channel 1 with junk valids elsewhere
        for (int i = 0; i < 8; i++) begin
            d   = 8'(i + 1);
            ev  = (i == 3) || (i == 7);
            odd = ((i % 2) == 1);
            tbl.push_back(mk("t2_b2b", 0, 1, odd, 8'hEE, 1, d, !odd, 8'hDD, ev, 0, ev,
                             (i == 3) ? 32'h01020304 : 32'h05060708, 4));
        end
        tbl.push_back(mk("t2_idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h05060708, 0));

        // Select change 2->0 with two characters pending
        tbl.push_back(mk("t3_aa", 0, 2, 0, 0, 0, 0, 1, 8'hAA, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t3_bb", 0, 2, 0, 0, 0, 0, 1, 8'hBB, 0, 0, 0, 0, 0));
`ifdef MUX_PARTIAL_FLUSH_EN
        tbl.push_back(mk("t3_chg", 0, 0, 1, 8'h11, 0, 0, 1, 8'hCC, 1, 0, 1, 32'hAABB0000, 2));
`else
        tbl.push_back(mk("t3_chg", 0, 0, 1, 8'h11, 0, 0, 1, 8'hCC, 0, 1, 0, 0, 0));
`endif
        tbl.push_back(mk("t3_12", 0, 0, 1, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t3_13", 0, 0, 1, 8'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t3_14", 0, 0, 1, 8'h14, 0, 0, 0, 0, 1, 0, 1, 32'h11121314, 4));

        // Select 3 mid-word, then back to 0 (silent in IDLE), leaving an incomplete word
        tbl.push_back(mk("t4_10", 0, 0, 1, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t4_20", 0, 0, 1, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef MUX_PARTIAL_FLUSH_EN
        tbl.push_back(mk("t4_sel3", 0, 3, 1, 8'h99, 0, 0, 0, 0, 1, 0, 1, 32'h10200000, 2));
`else
        tbl.push_back(mk("t4_sel3", 0, 3, 1, 8'h99, 0, 0, 0, 0, 0, 1, 0, 0, 0));
`endif
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk("t4_hold3", 0, 3, 1, 8'h99, 1, 8'h77, 1, 8'h66, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t4_30", 0, 0, 1, 8'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t4_40", 0, 0, 1, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t4_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0));

        // Reset mid-word discards silently
        tbl.push_back(mk("t5_10", 0, 0, 1, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t5_20", 0, 0, 1, 8'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t5_30", 0, 0, 1, 8'h30, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t5_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0));
        for (int i = 0; i < 4; i++) begin
            d  = 8'(i + 1);
            ev = (i == 3);
            tbl.push_back(mk("t5_word", 0, 0, 1, d, 0, 0, 0, 0, ev, 0, ev, 32'h01020304, 4));
        end

        // Unselected channel valid is ignored
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk("t6_ignore", 0, 0, 0, 0, 1, 8'h55, 0, 0, 0, 0, 1, 32'h01020304, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Hand-written: select change at count=NB-1 with a same-cycle accept on the new channel
        step(mk("h_a1", 0, 0, 1, 8'hA1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk("h_a2", 0, 0, 1, 8'hA2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk("h_a3", 0, 0, 1, 8'hA3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef MUX_PARTIAL_FLUSH_EN
        step(mk("h_chg", 0, 1, 1, 8'hA4, 1, 8'hB1, 0, 0, 1, 0, 1, 32'hA1A2A300, 3));
`else
        step(mk("h_chg", 0, 1, 1, 8'hA4, 1, 8'hB1, 0, 0, 0, 1, 1, 32'h01020304, 0));
`endif
        step(mk("h_b2", 0, 1, 0, 0, 1, 8'hB2, 0, 0, 0, 0, 0, 0, 0));
        step(mk("h_b3", 0, 1, 0, 0, 1, 8'hB3, 0, 0, 0, 0, 0, 0, 0));
        step(mk("h_b4", 0, 1, 0, 0, 1, 8'hB4, 0, 0, 1, 0, 1, 32'hB1B2B3B4, 4));
        step(mk("h_idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB1B2B3B4, 0));

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
